upd_issue_queue: RTL and testbench

Update issue queue sitting directly upstream of the hazard detection unit (`hdux1`) in the vertex-update path. It buffers incoming edge updates (destination address + payload) in a FIFO and presents the head address to the HDU read port (`Raddr0`/`Raddr_valid0`). It advances only when the HDU's `stall_signal` is low, and forwards each issued update downstream to the vertex-memory read stage. It guarantees that no update is dropped or duplicated across stalls.

---
 rtl/upd_issue_queue_if.sv | 45 ++++
 rtl/upd_issue_queue.sv | 141 ++++++++++++++
 tb/tb_upd_issue_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/upd_issue_queue_if.sv
// Handshake bundle between an update source / HDU and upd_issue_queue.
// Latency: none (wiring only).
// Backpressure: in_ready from the queue; stall_signal from the HDU.
// Optional macro UPD_ISSUE_STATS_EN adds the stall_cycles / issued_cnt counters.
interface upd_issue_queue_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int Bank_Num_W = 5
);
  logic [ADDR_W-1:0]     in_addr;
  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     Raddr0;
  logic                  Raddr_valid0;
  logic                  stall_signal;
  logic [ADDR_W-1:0]     out_addr;
  logic [Bank_Num_W-1:0] out_bank;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  flush;
  logic                  empty;
`ifdef UPD_ISSUE_STATS_EN
  logic [31:0]           stall_cycles;
  logic [31:0]           issued_cnt;
`endif

  // Queue side
  modport slave (
    input  in_addr, in_data, in_valid, stall_signal, flush,
    output in_ready, Raddr0, Raddr_valid0, out_addr, out_bank, out_data, out_valid, empty
`ifdef UPD_ISSUE_STATS_EN
    , output stall_cycles, issued_cnt
`endif
  );

  // Upstream producer + HDU + downstream consumer side
  modport master (
    output in_addr, in_data, in_valid, stall_signal, flush,
    input  in_ready, Raddr0, Raddr_valid0, out_addr, out_bank, out_data, out_valid, empty
`ifdef UPD_ISSUE_STATS_EN
    , input stall_cycles, issued_cnt
`endif
  );
endinterface

// File: rtl/upd_issue_queue.sv
// Update issue queue: FIFO of edge updates in front of the HDU, issues head when not stalled.
// Latency: write-to-present 1 cycle; issue-to-out_valid 1 cycle; 1 update/cycle sustained.
// Backpressure: in_ready = not full (current count only) and not flush; stall holds the head.
// Optional macro UPD_ISSUE_STATS_EN adds saturating stall_cycles / issued_cnt counters.
module upd_issue_queue #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int DEPTH_W    = 3,
  parameter int Bank_Num_W = 5
) (
  input logic              clk,
  input logic              rst,
  upd_issue_queue_if.slave q
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  logic [ADDR_W-1:0]     addr_mem [DEPTH];
  logic [DATA_W-1:0]     data_mem [DEPTH];
  logic [DEPTH_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]      count;
  state_e                state_q, state_d;
  logic                  push, pop, fifo_empty, full, last_pop;
  logic [ADDR_W-1:0]     out_addr_q;
  logic [Bank_Num_W-1:0] out_bank_q;
  logic [DATA_W-1:0]     out_data_q;
  logic                  out_valid_q;

  // Wrap bit on the pointers separates full from empty.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign full       = (count == FULL_CNT);

  // Ready never depends on stall_signal, so a full queue refuses a push even when it pops.
  assign q.in_ready     = !full && !q.flush;
  assign q.empty        = fifo_empty;
  assign q.Raddr_valid0 = !fifo_empty;
  assign q.Raddr0       = addr_mem[rd_ptr_q[DEPTH_W-1:0]];

  assign push     = q.in_valid && q.in_ready;
  assign pop      = !fifo_empty && !q.stall_signal && !q.flush;
  assign last_pop = pop && !push && (count == (DEPTH_W+1)'(1));

  // Pointer next-state; flush drops every queued entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Issue FSM next-state: IDLE empty, RUN flowing, HOLD head frozen by stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (push) state_d = RUN;
      RUN: begin
        if (last_pop)            state_d = IDLE;
        else if (q.stall_signal) state_d = HOLD;
      end
      HOLD: if (!q.stall_signal) state_d = last_pop ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
    if (q.flush) state_d = IDLE;
  end

  // Pointer and FSM state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[DEPTH_W-1:0]] <= q.in_addr;
      data_mem[wr_ptr_q[DEPTH_W-1:0]] <= q.in_data;
    end
  end

  // Registered issue stage toward vertex-memory read; out_valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_addr_q  <= '0;
      out_bank_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= pop;
      if (pop) begin
        out_addr_q <= q.Raddr0;
        out_bank_q <= q.Raddr0[Bank_Num_W-1:0];
        out_data_q <= data_mem[rd_ptr_q[DEPTH_W-1:0]];
      end
    end
  end

  assign q.out_addr  = out_addr_q;
  assign q.out_bank  = out_bank_q;
  assign q.out_data  = out_data_q;
  assign q.out_valid = out_valid_q;

`ifdef UPD_ISSUE_STATS_EN
  logic [31:0] stall_cycles_q, issued_cnt_q;

  // Saturating counters of stalled-presented cycles and issued pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      issued_cnt_q   <= '0;
    end else if (q.flush) begin
      stall_cycles_q <= '0;
      issued_cnt_q   <= '0;
    end else begin
      if (!fifo_empty && q.stall_signal && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (out_valid_q && (issued_cnt_q != '1))
        issued_cnt_q <= issued_cnt_q + 32'd1;
    end
  end

  assign q.stall_cycles = stall_cycles_q;
  assign q.issued_cnt   = issued_cnt_q;
`endif

endmodule

// File: tb/tb_upd_issue_queue.sv
// Directed bench for upd_issue_queue: reset, streaming, stall hold, full, flush, async reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Each scenario task holds its own table of hand-computed expectations.
module tb_upd_issue_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  upd_issue_queue_if #(.ADDR_W(16), .DATA_W(32), .Bank_Num_W(5)) bus ();

  upd_issue_queue #(.ADDR_W(16), .DATA_W(32), .DEPTH_W(3), .Bank_Num_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  // One cycle: drive after the edge, return at the following falling edge for sampling.
  task automatic cyc(input logic v, input logic [15:0] a, input logic s, input logic f);
    @(posedge clk);
    #1;
    bus.in_valid     = v;
    bus.in_addr      = a;
    bus.in_data      = 32'(a) + 32'd1000;
    bus.stall_signal = s;
    bus.flush        = f;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    bus.stall_signal = 1'b0; bus.flush = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1)     begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.empty !== 1'b1)        begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.Raddr_valid0 !== 1'b0) begin bad++; $display("FAIL reset_raddr_valid got=%b exp=0", bus.Raddr_valid0); end
    total++; if (bus.out_valid !== 1'b0)    begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_addr !== 16'd0)    begin bad++; $display("FAIL reset_out_addr got=%0d exp=0", bus.out_addr); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_streaming();
    logic        pv  [6] = '{1, 1, 1, 0, 0, 0};
    logic [15:0] pa  [6] = '{10, 5, 6, 0, 0, 0};
    logic        eov [6] = '{0, 0, 1, 1, 1, 0};
    logic [15:0] ea  [6] = '{0, 0, 10, 5, 6, 0};
    for (int i = 0; i < 6; i++) begin
      cyc(pv[i], pa[i], 1'b0, 1'b0);
      total++; if (bus.out_valid !== eov[i]) begin bad++; $display("FAIL stream_ov[%0d] got=%b exp=%b", i, bus.out_valid, eov[i]); end
      if (eov[i]) begin
        total++; if (bus.out_addr !== ea[i])                begin bad++; $display("FAIL stream_addr[%0d] got=%0d exp=%0d", i, bus.out_addr, ea[i]); end
        total++; if (bus.out_bank !== ea[i][4:0])           begin bad++; $display("FAIL stream_bank[%0d] got=%0d exp=%0d", i, bus.out_bank, ea[i][4:0]); end
        total++; if (bus.out_data !== 32'(ea[i]) + 32'd1000) begin bad++; $display("FAIL stream_data[%0d] got=%0d exp=%0d", i, bus.out_data, 32'(ea[i]) + 32'd1000); end
      end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL stream_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_stall_hold();
    logic pv  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic st  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic eov [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(pv[i], 16'd10, st[i], 1'b0);
      total++; if (bus.out_valid !== eov[i]) begin bad++; $display("FAIL hold_ov[%0d] got=%b exp=%b", i, bus.out_valid, eov[i]); end
      if (i >= 1 && i <= 5) begin
        total++; if (bus.Raddr0 !== 16'd10 || bus.Raddr_valid0 !== 1'b1)
          begin bad++; $display("FAIL hold_raddr[%0d] got=%0d/%b exp=10/1", i, bus.Raddr0, bus.Raddr_valid0); end
      end
      if (eov[i]) begin
        total++; if (bus.out_addr !== 16'd10) begin bad++; $display("FAIL hold_addr got=%0d exp=10", bus.out_addr); end
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] a;
    logic        v, s;
    for (int i = 0; i < 19; i++) begin
      v = (i <= 9);
      a = (i == 9) ? 16'd99 : 16'(20 + i);
      s = (i <= 8);
      cyc(v, a, s, 1'b0);
      if (i <= 9) begin
        total++; if (bus.in_ready !== (i <= 7)) begin bad++; $display("FAIL full_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, (i <= 7)); end
      end
      if (i == 8) begin
        total++; if (bus.Raddr0 !== 16'd20) begin bad++; $display("FAIL full_head got=%0d exp=20", bus.Raddr0); end
      end
      total++; if (bus.out_valid !== (i >= 10 && i <= 17)) begin bad++; $display("FAIL full_ov[%0d] got=%b exp=%b", i, bus.out_valid, (i >= 10 && i <= 17)); end
      if (i >= 10 && i <= 17) begin
        total++; if (bus.out_addr !== 16'(i + 10)) begin bad++; $display("FAIL full_order[%0d] got=%0d exp=%0d", i, bus.out_addr, i + 10); end
      end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b exp=1", bus.empty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(40 + i), 1'b1, 1'b0);
    cyc(1'b1, 16'd77, 1'b1, 1'b1);
    total++; if (bus.in_ready !== 1'b0)     begin bad++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.Raddr_valid0 !== 1'b1) begin bad++; $display("FAIL flush_prequeued got=%b exp=1", bus.Raddr_valid0); end
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    total++; if (bus.empty !== 1'b1 || bus.Raddr_valid0 !== 1'b0)
      begin bad++; $display("FAIL flush_empty got=%b/%b exp=1/0", bus.empty, bus.Raddr_valid0); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b0);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ov[%0d] got=%b exp=0", i, bus.out_valid); end
    end
    // Flush in the same cycle as an unstalled issue must swallow that issue.
    cyc(1'b1, 16'd50, 1'b0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    total++; if (bus.Raddr0 !== 16'd50) begin bad++; $display("FAIL flush_issue_head got=%0d exp=50", bus.Raddr0); end
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    total++; if (bus.out_valid !== 1'b0 || bus.empty !== 1'b1)
      begin bad++; $display("FAIL flush_issue_suppressed got=%b/%b exp=0/1", bus.out_valid, bus.empty); end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 16'd60, 1'b0, 1'b0);
    cyc(1'b1, 16'd61, 1'b1, 1'b0);
    cyc(1'b1, 16'd62, 1'b1, 1'b0);
    cyc(1'b1, 16'd63, 1'b1, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.stall_signal = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 16'd60 || bus.Raddr_valid0 !== 1'b1)
      begin bad++; $display("FAIL areset_pre got=%b/%0d/%b exp=1/60/1", bus.out_valid, bus.out_addr, bus.Raddr_valid0); end
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 16'd0 || bus.out_data !== 32'd0)
      begin bad++; $display("FAIL areset_out got=%b/%0d/%0d exp=0/0/0", bus.out_valid, bus.out_addr, bus.out_data); end
    total++; if (bus.empty !== 1'b1 || bus.Raddr_valid0 !== 1'b0 || bus.in_ready !== 1'b1)
      begin bad++; $display("FAIL areset_fifo got=%b/%b/%b exp=1/0/1", bus.empty, bus.Raddr_valid0, bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 16'd70; bus.in_data = 32'd1070; bus.stall_signal = 1'b0;
    @(negedge clk);
    total++; if (bus.Raddr_valid0 !== 1'b0) begin bad++; $display("FAIL b2b_pre got=%b exp=0", bus.Raddr_valid0); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.Raddr0 !== 16'd70 || bus.Raddr_valid0 !== 1'b1)
      begin bad++; $display("FAIL b2b_first_accept got=%0d/%b exp=70/1", bus.Raddr0, bus.Raddr_valid0); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 16'd70 || bus.empty !== 1'b1)
      begin bad++; $display("FAIL b2b_issue got=%b/%0d/%b exp=1/70/1", bus.out_valid, bus.out_addr, bus.empty); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_hold();
    test_full();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
